// File: rtl/datapath_sequencer.sv
// datapath_sequencer: accepts one command at a time, steps the external datapath through
// load/execute/writeback, then returns a single response carrying C, Z and an error flag.
module datapath_sequencer #(
  parameter bit SIGN_EXT_IMM = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [2:0]  cmd_rd,
  input  logic [2:0]  cmd_rn,
  input  logic [2:0]  cmd_rm,
  input  logic [1:0]  cmd_shift,
  input  logic [7:0]  cmd_imm,
  input  logic [15:0] datapath_out,
  input  logic        Z_out,
  output logic [2:0]  readnum,
  output logic [2:0]  writenum,
  output logic        write,
  output logic        vsel,
  output logic        loada,
  output logic        loadb,
  output logic        asel,
  output logic        bsel,
  output logic        loadc,
  output logic        loads,
  output logic [1:0]  shift,
  output logic [1:0]  ALUop,
  output logic [15:0] datapath_in,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_data,
  output logic        rsp_z,
  output logic        rsp_err,
  output logic [2:0]  dbg_state
);
  // Both channels use valid/ready: a transfer happens at a rising edge where valid and
  // ready are both 1. cmd_ready is 1 only in IDLE; rsp_valid is 1 only in RESP and stays
  // up, with stable payload, until the transfer completes.

  localparam logic [2:0] OP_MOVI = 3'b000;
  localparam logic [2:0] OP_MOV  = 3'b001;
  localparam logic [2:0] OP_ADD  = 3'b010;
  localparam logic [2:0] OP_CMP  = 3'b011;
  localparam logic [2:0] OP_AND  = 3'b100;
  localparam logic [2:0] OP_MVN  = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOADA = 3'd1,
    S_LOADB = 3'd2,
    S_EXEC  = 3'd3,
    S_WRITE = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  op_q, rd_q, rn_q, rm_q;
  logic [1:0]  shift_q;
  logic [7:0]  imm_q;
  logic [15:0] imm_ext;
  logic        q_illegal, q_movi, q_cmp, q_unary;

  assign imm_ext   = SIGN_EXT_IMM ? {{8{imm_q[7]}}, imm_q} : {8'h00, imm_q};
  assign q_illegal = (op_q == 3'b110) || (op_q == 3'b111);
  assign q_movi    = (op_q == OP_MOVI);
  assign q_cmp     = (op_q == OP_CMP);
  assign q_unary   = (op_q == OP_MOV) || (op_q == OP_MVN);
  assign dbg_state = state_q;

  // Entry state depends on which operands an opcode needs; illegal ops answer at once.
  function automatic state_t first_state(input logic [2:0] op);
    case (op)
      OP_MOVI:                first_state = S_WRITE;
      OP_MOV, OP_MVN:         first_state = S_LOADB;
      OP_ADD, OP_CMP, OP_AND: first_state = S_LOADA;
      default:                first_state = S_RESP;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= 3'b000;
      rd_q    <= 3'b000;
      rn_q    <= 3'b000;
      rm_q    <= 3'b000;
      shift_q <= 2'b00;
      imm_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE && cmd_valid) begin
        op_q    <= cmd_op;
        rd_q    <= cmd_rd;
        rn_q    <= cmd_rn;
        rm_q    <= cmd_rm;
        shift_q <= cmd_shift;
        imm_q   <= cmd_imm;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_ready   = 1'b0;
    readnum     = 3'b000;
    writenum    = 3'b000;
    write       = 1'b0;
    vsel        = 1'b0;
    loada       = 1'b0;
    loadb       = 1'b0;
    asel        = 1'b0;
    bsel        = 1'b0;
    loadc       = 1'b0;
    loads       = 1'b0;
    shift       = 2'b00;
    ALUop       = 2'b00;
    datapath_in = 16'h0000;
    rsp_valid   = 1'b0;
    rsp_data    = 16'h0000;
    rsp_z       = 1'b0;
    rsp_err     = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = first_state(cmd_op);
      end
      S_LOADA: begin
        readnum = rn_q;
        loada   = 1'b1;
        state_d = S_LOADB;
      end
      S_LOADB: begin
        readnum = rm_q;
        loadb   = 1'b1;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        // MOV/MVN zero the A input so the ALU passes (or inverts) the shifted B operand.
        shift = shift_q;
        asel  = q_unary;
        loadc = 1'b1;
        loads = 1'b1;
        case (op_q)
          OP_CMP:  ALUop = 2'b01;
          OP_AND:  ALUop = 2'b10;
          OP_MVN:  ALUop = 2'b11;
          default: ALUop = 2'b00;
        endcase
        state_d = q_cmp ? S_RESP : S_WRITE;
      end
      S_WRITE: begin
        write       = 1'b1;
        writenum    = rd_q;
        vsel        = q_movi;
        datapath_in = q_movi ? imm_ext : 16'h0000;
        state_d     = S_RESP;
      end
      S_RESP: begin
        // C and Z stay put here because loadc/loads are low, so the payload is stable.
        rsp_valid = 1'b1;
        rsp_err   = q_illegal;
        rsp_data  = q_illegal ? 16'h0000 : (q_movi ? imm_ext : datapath_out);
        rsp_z     = (q_illegal || q_movi) ? 1'b0 : Z_out;
        if (rsp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_datapath_sequencer.sv
// Bench for datapath_sequencer: a behavioural datapath answers the control bundle, and a
// per-command reference model predicts timing, control values and the response.
module tb_datapath_sequencer;
  localparam bit SX0 = 1'b0;
  localparam logic [2:0] OP_MOVI = 3'd0, OP_MOV = 3'd1, OP_ADD = 3'd2;
  localparam logic [2:0] OP_CMP = 3'd3, OP_AND = 3'd4, OP_MVN = 3'd5;

  typedef struct {
    int          lat, ca, cb, ce, cw, na, nb, nc, ns, nw;
    logic [2:0]  ra, rb, wnum;
    logic        vsel;
    logic [15:0] din;
    logic [1:0]  aluop, shamt;
    logic        asel, bsel;
    logic [15:0] data;
    logic        z, err;
  } txn_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // ---------------- DUT 0 (zero-extended immediate) ----------------
  logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_z, rsp_err;
  logic [2:0]  cmd_op, cmd_rd, cmd_rn, cmd_rm, readnum, writenum, dbg_state;
  logic [1:0]  cmd_shift, shift, ALUop;
  logic [7:0]  cmd_imm;
  logic [15:0] datapath_out, datapath_in, rsp_data;
  logic        Z_out, write, vsel, loada, loadb, asel, bsel, loadc, loads;

  datapath_sequencer dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_rd(cmd_rd), .cmd_rn(cmd_rn), .cmd_rm(cmd_rm),
    .cmd_shift(cmd_shift), .cmd_imm(cmd_imm), .datapath_out(datapath_out), .Z_out(Z_out),
    .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel), .loada(loada),
    .loadb(loadb), .asel(asel), .bsel(bsel), .loadc(loadc), .loads(loads), .shift(shift),
    .ALUop(ALUop), .datapath_in(datapath_in), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_z(rsp_z), .rsp_err(rsp_err), .dbg_state(dbg_state)
  );

  // ---------------- DUT 1 (sign-extended immediate) ----------------
  logic        x_cmd_valid, x_cmd_ready, x_rsp_valid, x_rsp_z, x_rsp_err, x_z_out;
  logic        x_rsp_ready;
  logic [2:0]  x_cmd_op, x_cmd_rd, x_cmd_rn, x_cmd_rm, x_readnum, x_writenum, x_dbg_state;
  logic [1:0]  x_cmd_shift, x_shift, x_aluop;
  logic [7:0]  x_cmd_imm;
  logic [15:0] x_dp_out, x_datapath_in, x_rsp_data;
  logic        x_write, x_vsel, x_loada, x_loadb, x_asel, x_bsel, x_loadc, x_loads;

  datapath_sequencer #(.SIGN_EXT_IMM(1'b1)) dut_sx (
    .clk(clk), .reset(reset), .cmd_valid(x_cmd_valid), .cmd_ready(x_cmd_ready),
    .cmd_op(x_cmd_op), .cmd_rd(x_cmd_rd), .cmd_rn(x_cmd_rn), .cmd_rm(x_cmd_rm),
    .cmd_shift(x_cmd_shift), .cmd_imm(x_cmd_imm), .datapath_out(x_dp_out), .Z_out(x_z_out),
    .readnum(x_readnum), .writenum(x_writenum), .write(x_write), .vsel(x_vsel),
    .loada(x_loada), .loadb(x_loadb), .asel(x_asel), .bsel(x_bsel), .loadc(x_loadc),
    .loads(x_loads), .shift(x_shift), .ALUop(x_aluop), .datapath_in(x_datapath_in),
    .rsp_valid(x_rsp_valid), .rsp_ready(x_rsp_ready), .rsp_data(x_rsp_data),
    .rsp_z(x_rsp_z), .rsp_err(x_rsp_err), .dbg_state(x_dbg_state)
  );

  // ---------------- behavioural datapath (environment for DUT 0) ----------------
  function automatic logic [15:0] sh16(input logic [15:0] x, input logic [1:0] s);
    case (s)
      2'b00:   return x;
      2'b01:   return {x[14:0], 1'b0};
      2'b10:   return {1'b0, x[15:1]};
      default: return {x[15], x[15:1]};
    endcase
  endfunction

  logic [15:0] dp_r [8] = '{default: 16'h0};
  logic [15:0] dp_a = 16'h0, dp_b = 16'h0, dp_c = 16'h0;
  logic        dp_z = 1'b0;
  logic [15:0] dp_ain, dp_bin, dp_alu;

  always_comb begin
    dp_ain = asel ? 16'h0 : dp_a;
    dp_bin = bsel ? {11'h0, datapath_in[4:0]} : sh16(dp_b, shift);
    case (ALUop)
      2'b00:   dp_alu = dp_ain + dp_bin;
      2'b01:   dp_alu = dp_ain - dp_bin;
      2'b10:   dp_alu = dp_ain & dp_bin;
      default: dp_alu = ~dp_bin;
    endcase
  end

  always @(posedge clk) begin
    if (write) dp_r[writenum] <= vsel ? datapath_in : dp_c;
    if (loada) dp_a <= dp_r[readnum];
    if (loadb) dp_b <= dp_r[readnum];
    if (loadc) dp_c <= dp_alu;
    if (loads) dp_z <= (dp_alu == 16'h0);
  end

  assign datapath_out = dp_c;
  assign Z_out        = dp_z;

  // ---------------- reference model ----------------
  logic [15:0] mdl_r [8] = '{default: 16'h0};
  int checks = 0;
  int failures = 0;

  // Predicts one command from the opcode table: which phases it visits (cycle index after
  // the handshake), the control values in each, the response, and the register update.
  task automatic model_cmd(input logic [2:0] op, rd, rn, rm, input logic [1:0] sh,
                           input logic [7:0] imm, output txn_t e);
    logic [15:0] a, b, r, ext;
    bit legal, use_a, use_b, wr;
    ext   = SX0 ? {{8{imm[7]}}, imm} : {8'h00, imm};
    legal = (op <= 3'd5);
    use_a = (op == OP_ADD) || (op == OP_CMP) || (op == OP_AND);
    use_b = legal && (op != OP_MOVI);
    wr    = legal && (op != OP_CMP);
    a = mdl_r[rn];
    b = sh16(mdl_r[rm], sh);
    case (op)
      OP_MOVI: r = ext;
      OP_MOV:  r = b;
      OP_ADD:  r = a + b;
      OP_CMP:  r = a - b;
      OP_AND:  r = a & b;
      OP_MVN:  r = ~b;
      default: r = 16'h0;
    endcase
    e = '{default: 0};
    e.lat = 1 + int'(use_a) + 2 * int'(use_b) + int'(wr);
    e.ca  = use_a ? 1 : -1;
    e.cb  = use_b ? 1 + int'(use_a) : -1;
    e.ce  = use_b ? 2 + int'(use_a) : -1;
    e.cw  = wr ? e.lat - 1 : -1;
    e.na  = int'(use_a);
    e.nb  = int'(use_b);
    e.nc  = int'(use_b);
    e.ns  = int'(use_b);
    e.nw  = int'(wr);
    e.ra  = use_a ? rn : 3'd0;
    e.rb  = use_b ? rm : 3'd0;
    e.wnum = wr ? rd : 3'd0;
    e.vsel = (op == OP_MOVI);
    e.din  = (op == OP_MOVI) ? ext : 16'h0;
    if (use_b) begin
      e.aluop = (op == OP_CMP) ? 2'd1 : (op == OP_AND) ? 2'd2 : (op == OP_MVN) ? 2'd3 : 2'd0;
      e.asel  = (op == OP_MOV) || (op == OP_MVN);
      e.shamt = sh;
    end
    e.data = r;
    e.z    = (legal && op != OP_MOVI) ? (r == 16'h0) : 1'b0;
    e.err  = !legal;
    if (wr) mdl_r[rd] = r;
  endtask

  function automatic string fmt_time(input txn_t t);
    return $sformatf("lat=%0d a@%0d b@%0d e@%0d w@%0d", t.lat, t.ca, t.cb, t.ce, t.cw);
  endfunction
  function automatic string fmt_ctrl(input txn_t t);
    return $sformatf("n=%0d/%0d/%0d/%0d/%0d ra=%0d rb=%0d wn=%0d vsel=%b din=%h alu=%0d asel=%b bsel=%b sh=%0d",
                     t.na, t.nb, t.nc, t.ns, t.nw, t.ra, t.rb, t.wnum, t.vsel, t.din,
                     t.aluop, t.asel, t.bsel, t.shamt);
  endfunction
  function automatic string fmt_rsp(input txn_t t);
    return $sformatf("data=%h z=%b err=%b", t.data, t.z, t.err);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic scramble_cmd();
    cmd_op    = 3'($urandom_range(0, 7));
    cmd_rd    = 3'($urandom_range(0, 7));
    cmd_rn    = 3'($urandom_range(0, 7));
    cmd_rm    = 3'($urandom_range(0, 7));
    cmd_shift = 2'($urandom_range(0, 3));
    cmd_imm   = 8'($urandom_range(0, 255));
  endtask

  // Called at a falling edge; returns at the falling edge of the first cycle after the handshake.
  task automatic issue_cmd(input logic [2:0] op, rd, rn, rm, input logic [1:0] sh,
                           input logic [7:0] imm, input bit hold, output bit to);
    to = 1'b0;
    for (int i = 0; i < 20 && cmd_ready !== 1'b1; i++) @(negedge clk);
    if (cmd_ready !== 1'b1) begin
      to = 1'b1;
      return;
    end
    cmd_op = op; cmd_rd = rd; cmd_rn = rn; cmd_rm = rm; cmd_shift = sh; cmd_imm = imm;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    if (hold) scramble_cmd();
    else cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  // Observes the command in flight, stalls the response for stall_cyc cycles, then accepts it.
  task automatic collect(input int stall_cyc, input bit scramble, output txn_t o,
                         output bit stable, output bit busy_rdy, output bit to);
    o = '{default: 0};
    o.ca = -1; o.cb = -1; o.ce = -1; o.cw = -1;
    stable = 1'b1; busy_rdy = 1'b0; to = 1'b0;
    for (int c = 1; c <= 30; c++) begin
      if (loada) begin o.na++; o.ca = c; o.ra = readnum; end
      if (loadb) begin o.nb++; o.cb = c; o.rb = readnum; end
      if (loadc) begin
        o.nc++; o.ce = c; o.aluop = ALUop; o.asel = asel; o.bsel = bsel; o.shamt = shift;
      end
      if (loads) o.ns++;
      if (write) begin
        o.nw++; o.cw = c; o.wnum = writenum; o.vsel = vsel;
        o.din = vsel ? datapath_in : 16'h0;
      end
      if (cmd_ready) busy_rdy = 1'b1;
      if (rsp_valid) begin
        o.lat = c;
        break;
      end
      if (scramble) scramble_cmd();
      @(negedge clk);
    end
    if (o.lat == 0) begin
      to = 1'b1;
      return;
    end
    o.data = rsp_data; o.z = rsp_z; o.err = rsp_err;
    for (int k = 0; k < stall_cyc; k++) begin
      @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_data !== o.data || rsp_z !== o.z || rsp_err !== o.err ||
          loada || loadb || loadc || loads || write || cmd_ready)
        stable = 1'b0;
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    if (scramble) scramble_cmd();
    @(negedge clk);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || x_cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_cmd_ready: got %b/%b, want 1/1", cmd_ready, x_cmd_ready);
    end
    checks++;
    if ({rsp_valid, rsp_err, rsp_z, rsp_data} !== 19'h0) begin
      failures++;
      $display("FAIL reset_rsp: got valid=%b err=%b z=%b data=%h, want all 0",
               rsp_valid, rsp_err, rsp_z, rsp_data);
    end
    checks++;
    if ({readnum, writenum, write, vsel, loada, loadb, asel, bsel, loadc, loads, shift, ALUop,
         datapath_in} !== 40'h0) begin
      failures++;
      $display("FAIL reset_ctrl: got %s din=%h, want all 0",
               $sformatf("rn=%0d wn=%0d w=%b v=%b la=%b lb=%b as=%b bs=%b lc=%b ls=%b sh=%0d alu=%0d",
                 readnum, writenum, write, vsel, loada, loadb, asel, bsel, loadc, loads, shift, ALUop),
               datapath_in);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_movi();
    txn_t o, e;
    bit to, st, br, to2;
    model_cmd(OP_MOVI, 3'd3, 3'd0, 3'd0, 2'd0, 8'h85, e);
    issue_cmd(OP_MOVI, 3'd3, 3'd0, 3'd0, 2'd0, 8'h85, 1'b0, to);
    collect(0, 1'b0, o, st, br, to2);
    checks++;
    if (to || to2 || o.lat !== 2 || o.cw !== 1 || o.wnum !== 3'd3 || o.vsel !== 1'b1 ||
        o.din !== 16'h0085) begin
      failures++;
      $display("FAIL movi_write: got %s | %s, want lat=2 w@1 wn=3 vsel=1 din=0085",
               fmt_time(o), fmt_ctrl(o));
    end
    checks++;
    if (o.data !== 16'h0085 || o.z !== 1'b0 || o.err !== 1'b0) begin
      failures++;
      $display("FAIL movi_rsp: got %s, want data=0085 z=0 err=0", fmt_rsp(o));
    end
    // Sign-extending instance, fixed-cycle sequence
    x_cmd_op = OP_MOVI; x_cmd_rd = 3'd3; x_cmd_imm = 8'h85; x_cmd_valid = 1'b1;
    @(posedge clk);
    #1 x_cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (x_write !== 1'b1 || x_writenum !== 3'd3 || x_vsel !== 1'b1 || x_datapath_in !== 16'hFF85) begin
      failures++;
      $display("FAIL movi_sx_write: got w=%b wn=%0d vsel=%b din=%h, want 1 3 1 ff85",
               x_write, x_writenum, x_vsel, x_datapath_in);
    end
    @(negedge clk);
    checks++;
    if (x_rsp_valid !== 1'b1 || x_rsp_data !== 16'hFF85 || x_rsp_err !== 1'b0) begin
      failures++;
      $display("FAIL movi_sx_rsp: got valid=%b data=%h err=%b, want 1 ff85 0",
               x_rsp_valid, x_rsp_data, x_rsp_err);
    end
    @(negedge clk);
  endtask

  task automatic test_add();
    txn_t o, e;
    bit to, st, br, to2;
    model_cmd(OP_MOVI, 3'd1, 3'd0, 3'd0, 2'd0, 8'd7, e);
    issue_cmd(OP_MOVI, 3'd1, 3'd0, 3'd0, 2'd0, 8'd7, 1'b0, to);
    collect(0, 1'b0, o, st, br, to2);
    model_cmd(OP_MOVI, 3'd2, 3'd0, 3'd0, 2'd0, 8'd5, e);
    issue_cmd(OP_MOVI, 3'd2, 3'd0, 3'd0, 2'd0, 8'd5, 1'b0, to);
    collect(0, 1'b0, o, st, br, to2);
    model_cmd(OP_ADD, 3'd0, 3'd1, 3'd2, 2'd0, 8'd0, e);
    issue_cmd(OP_ADD, 3'd0, 3'd1, 3'd2, 2'd0, 8'd0, 1'b0, to);
    collect(0, 1'b0, o, st, br, to2);
    checks++;
    if (to || to2 || fmt_time(o) != "lat=5 a@1 b@2 e@3 w@4") begin
      failures++;
      $display("FAIL add_timing: got %s, want lat=5 a@1 b@2 e@3 w@4", fmt_time(o));
    end
    checks++;
    if (o.ra !== 3'd1 || o.rb !== 3'd2 || o.aluop !== 2'd0 || o.wnum !== 3'd0 || o.vsel !== 1'b0) begin
      failures++;
      $display("FAIL add_ctrl: got %s, want ra=1 rb=2 alu=0 wn=0 vsel=0", fmt_ctrl(o));
    end
    checks++;
    if (o.data !== 16'h000C || o.z !== 1'b0 || o.err !== 1'b0) begin
      failures++;
      $display("FAIL add_rsp: got %s, want data=000c z=0 err=0", fmt_rsp(o));
    end
  endtask

  task automatic test_cmp();
    txn_t o, e;
    bit to, st, br, to2;
    model_cmd(OP_CMP, 3'd6, 3'd1, 3'd1, 2'd0, 8'd0, e);
    issue_cmd(OP_CMP, 3'd6, 3'd1, 3'd1, 2'd0, 8'd0, 1'b0, to);
    collect(0, 1'b0, o, st, br, to2);
    checks++;
    if (to || to2 || o.lat !== 4 || o.nw !== 0 || o.aluop !== 2'd1) begin
      failures++;
      $display("FAIL cmp_seq: got %s | %s, want lat=4 no write alu=1", fmt_time(o), fmt_ctrl(o));
    end
    checks++;
    if (o.data !== 16'h0000 || o.z !== 1'b1 || o.err !== 1'b0) begin
      failures++;
      $display("FAIL cmp_rsp: got %s, want data=0000 z=1 err=0", fmt_rsp(o));
    end
  endtask

  task automatic test_illegal();
    txn_t o, e;
    bit to, st, br, to2;
    model_cmd(3'b111, 3'd2, 3'd1, 3'd1, 2'd0, 8'hAA, e);
    issue_cmd(3'b111, 3'd2, 3'd1, 3'd1, 2'd0, 8'hAA, 1'b0, to);
    collect(3, 1'b0, o, st, br, to2);
    checks++;
    if (to || to2 || o.lat !== 1 || (o.na + o.nb + o.nc + o.ns + o.nw) !== 0) begin
      failures++;
      $display("FAIL illegal_seq: got %s | %s, want lat=1 and no enables", fmt_time(o), fmt_ctrl(o));
    end
    checks++;
    if (o.err !== 1'b1 || o.data !== 16'h0000 || o.z !== 1'b0 || st !== 1'b1) begin
      failures++;
      $display("FAIL illegal_rsp: got %s stable=%b, want err=1 data=0000 z=0 stable=1", fmt_rsp(o), st);
    end
    checks++;
    if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL illegal_return: got cmd_ready=%b rsp_valid=%b, want 1 0", cmd_ready, rsp_valid);
    end
  endtask

  task automatic test_reset_midflight();
    txn_t o, e;
    bit to, st, br, to2;
    issue_cmd(OP_ADD, 3'd4, 3'd1, 3'd2, 2'd0, 8'd0, 1'b0, to);
    repeat (2) @(negedge clk);
    checks++;
    if (to || loadc !== 1'b1) begin
      failures++;
      $display("FAIL midreset_exec: got loadc=%b at cycle 3, want 1", loadc);
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({cmd_ready, loadc, write, rsp_valid} !== 4'b1000) begin
      failures++;
      $display("FAIL midreset_idle: got ready/loadc/write/rsp=%b, want 1000",
               {cmd_ready, loadc, write, rsp_valid});
    end
    @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || loada !== 1'b0 || cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL midreset_quiet: got rsp_valid=%b loada=%b cmd_ready=%b, want 0 0 1",
               rsp_valid, loada, cmd_ready);
    end
    // r4 must not have been written by the abandoned ADD
    model_cmd(OP_MOV, 3'd5, 3'd0, 3'd4, 2'd0, 8'd0, e);
    issue_cmd(OP_MOV, 3'd5, 3'd0, 3'd4, 2'd0, 8'd0, 1'b0, to);
    collect(0, 1'b0, o, st, br, to2);
    checks++;
    if (to || to2 || fmt_time(o) != fmt_time(e) || fmt_rsp(o) != fmt_rsp(e)) begin
      failures++;
      $display("FAIL midreset_next: got %s %s, want %s %s", fmt_time(o), fmt_rsp(o),
               fmt_time(e), fmt_rsp(e));
    end
  endtask

  task automatic test_reset_priority();
    cmd_op = OP_MOVI; cmd_rd = 3'd6; cmd_imm = 8'h11; cmd_valid = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1 || write !== 1'b0) begin
      failures++;
      $display("FAIL reset_priority: got cmd_ready=%b write=%b, want 1 0", cmd_ready, write);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    txn_t o, e;
    bit to, st, br, to2, hold;
    logic [2:0] op, rd, rn, rm;
    logic [1:0] sh;
    logic [7:0] imm;
    for (int i = 0; i < 60; i++) begin
      op = ($urandom_range(0, 3) == 0) ? OP_MOVI : 3'($urandom_range(0, 7));
      rd = 3'($urandom_range(0, 7)); rn = 3'($urandom_range(0, 7)); rm = 3'($urandom_range(0, 7));
      sh = 2'($urandom_range(0, 3)); imm = 8'($urandom_range(0, 255));
      hold = 1'($urandom_range(0, 1));
      model_cmd(op, rd, rn, rm, sh, imm, e);
      issue_cmd(op, rd, rn, rm, sh, imm, hold, to);
      if (!to) collect($urandom_range(0, 3), hold, o, st, br, to2);
      checks++;
      if (to || to2) begin
        failures++;
        $display("FAIL rnd_timeout: cmd %0d op=%0d saw no handshake or response in bound", i, op);
        break;
      end
      checks++;
      if (fmt_time(o) != fmt_time(e)) begin
        failures++;
        $display("FAIL rnd_timing[%0d] op=%0d: got %s, want %s", i, op, fmt_time(o), fmt_time(e));
      end
      checks++;
      if (fmt_ctrl(o) != fmt_ctrl(e)) begin
        failures++;
        $display("FAIL rnd_ctrl[%0d] op=%0d: got %s, want %s", i, op, fmt_ctrl(o), fmt_ctrl(e));
      end
      checks++;
      if (fmt_rsp(o) != fmt_rsp(e)) begin
        failures++;
        $display("FAIL rnd_rsp[%0d] op=%0d: got %s, want %s", i, op, fmt_rsp(o), fmt_rsp(e));
      end
      checks++;
      if (st !== 1'b1 || br !== 1'b0 || cmd_ready !== 1'b1) begin
        failures++;
        $display("FAIL rnd_handshake[%0d]: got stable=%b busy_ready=%b ready_after=%b, want 1 0 1",
                 i, st, br, cmd_ready);
      end
      cmd_valid = 1'b0;
    end
  endtask

  task automatic test_back_to_back();
    txn_t o, e;
    bit to, st, br, to2;
    logic [2:0] op, rd, rn, rm;
    logic [1:0] sh;
    logic [7:0] imm;
    for (int i = 0; i < 12; i++) begin
      op = 3'($urandom_range(0, 5));
      rd = 3'($urandom_range(0, 7)); rn = 3'($urandom_range(0, 7)); rm = 3'($urandom_range(0, 7));
      sh = 2'($urandom_range(0, 3)); imm = 8'($urandom_range(0, 255));
      model_cmd(op, rd, rn, rm, sh, imm, e);
      issue_cmd(op, rd, rn, rm, sh, imm, 1'b1, to);
      if (!to) collect(0, 1'b1, o, st, br, to2);
      checks++;
      if (to || to2 || fmt_time(o) != fmt_time(e) || fmt_rsp(o) != fmt_rsp(e) || br !== 1'b0) begin
        failures++;
        $display("FAIL b2b[%0d] op=%0d: got %s %s busy_ready=%b, want %s %s busy_ready=0",
                 i, op, fmt_time(o), fmt_rsp(o), br, fmt_time(e), fmt_rsp(e));
        break;
      end
    end
    cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    reset = 1'b1;
    cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_op = 3'd0; cmd_rd = 3'd0; cmd_rn = 3'd0; cmd_rm = 3'd0; cmd_shift = 2'd0; cmd_imm = 8'd0;
    x_cmd_valid = 1'b0; x_rsp_ready = 1'b1; x_dp_out = 16'h0; x_z_out = 1'b0;
    x_cmd_op = 3'd0; x_cmd_rd = 3'd0; x_cmd_rn = 3'd0; x_cmd_rm = 3'd0;
    x_cmd_shift = 2'd0; x_cmd_imm = 8'd0;
    @(negedge clk);
    test_reset();
    test_movi();
    test_add();
    test_cmp();
    test_illegal();
    test_reset_midflight();
    test_reset_priority();
    test_random();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule

// File: doc/datapath_sequencer.md
DATAPATH_SEQUENCER -- requirements
Module: datapath_sequencer

Interface
Parameters:
REQ-001 SHALL have parameter SIGN_EXT_IMM, default 0: 0 zero-extends cmd_imm[7:0] to 16 bits, 1 sign-extends it.
Ports (name direction width meaning):
REQ-002 SHALL have clk input 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have reset input 1: reset is synchronous and active-high.
REQ-004 SHALL have cmd_valid input 1, cmd_ready output 1, cmd_op input 3, cmd_rd input 3, cmd_rn input 3, cmd_rm input 3, cmd_shift input 2, cmd_imm input 8: command channel.
REQ-005 SHALL have datapath_out input 16 and Z_out input 1: datapath C register and status flag.
REQ-006 SHALL have readnum output 3, writenum output 3, write, vsel, loada, loadb, asel, bsel, loadc, loads output 1 each, shift output 2, ALUop output 2, datapath_in output 16: datapath control bundle.
REQ-007 SHALL have rsp_valid output 1, rsp_ready input 1, rsp_data output 16, rsp_z output 1, rsp_err output 1: response channel.

Function
REQ-008 SHALL use opcodes 000 MOVI (Rd=imm), 001 MOV (Rd=sh(Rm)), 010 ADD (Rd=Rn+sh(Rm)), 011 CMP (status of Rn-sh(Rm), no writeback), 100 AND (Rd=Rn&sh(Rm)), 101 MVN (Rd=~sh(Rm)); 110/111 illegal.
REQ-009 SHALL implement states IDLE, LOADA, LOADB, EXEC, WRITE, RESP.
REQ-010 SHALL drive cmd_ready=1 only in IDLE; handshake = cmd_valid&cmd_ready at a rising edge, which latches all cmd_* fields.
REQ-011 SHALL sequence after handshake: MOVI WRITE->RESP; ADD/AND LOADA->LOADB->EXEC->WRITE->RESP; CMP LOADA->LOADB->EXEC->RESP; MOV/MVN LOADB->EXEC->WRITE->RESP; illegal RESP directly.
REQ-012 SHALL give rsp_valid first asserted N cycles after the handshake cycle: illegal 1, MOVI 2, MOV/MVN/CMP 4, ADD/AND 5.
REQ-013 SHALL in LOADA drive readnum=Rn, loada=1; in LOADB drive readnum=Rm, loadb=1.
REQ-014 SHALL in EXEC drive shift=cmd_shift (forced 00 for none of the ops), bsel=0, asel=1 for MOV/MVN else 0, ALUop 00 ADD/MOV, 01 CMP, 10 AND, 11 MVN, loadc=1, loads=1.
REQ-015 SHALL in WRITE drive write=1, writenum=Rd, vsel=1 and datapath_in=extended imm for MOVI, vsel=0 otherwise.
REQ-016 SHALL hold every single-bit enable (write, loada, loadb, loadc, loads) at 0 outside its state; non-enable control outputs are don't-care when unused but SHALL be 0 in IDLE.
REQ-017 SHALL in RESP hold rsp_valid=1 until rsp_valid&rsp_ready at an edge, then return to IDLE; no IDLE bypass (one idle cycle minimum between commands).
REQ-018 SHALL drive rsp_data = extended imm for MOVI, 0 for illegal, datapath_out otherwise; rsp_z = Z_out for CMP/ADD/AND/MOV/MVN, 0 for MOVI/illegal; rsp_err=1 only for illegal.
REQ-019 SHALL keep rsp_data/rsp_z/rsp_err stable while rsp_valid=1 and rsp_ready=0 (datapath C is untouched since loadc=0).
REQ-020 SHALL ignore cmd_* changes while not in IDLE; no command is queued.

Reset
REQ-021 SHALL on reset high at an edge enter IDLE regardless of state, abandoning any in-flight command without response.
REQ-022 SHALL after reset drive cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_data=0, rsp_z=0, all control outputs and datapath_in = 0.
REQ-023 SHALL give reset priority over a simultaneous handshake on either channel.

Verification
REQ-024 MOVI rd=3 imm=0x85, SIGN_EXT_IMM=0 -> cycle T+1 write=1 writenum=3 vsel=1 datapath_in=0x0085; T+2 rsp_valid, rsp_data=0x0085; with SIGN_EXT_IMM=1 datapath_in=0xFF85.
REQ-025 R1=7,R2=5 (via MOVI), ADD rd=0 rn=1 rm=2 shift=00 -> loada T+1 readnum=1, loadb T+2 readnum=2, EXEC T+3 ALUop=00, write T+4 writenum=0; T+5 rsp_data=0x000C, rsp_z=0.
REQ-026 CMP rn=1 rm=1 -> write never asserted, rsp_valid at T+4, rsp_z=1, rsp_data=0x0000.
REQ-027 cmd_op=111 -> rsp_valid at T+1, rsp_err=1, no enable asserted; rsp_ready=0 for 3 cycles -> outputs held stable; then rsp_ready=1 -> IDLE, cmd_ready=1 next cycle.
REQ-028 reset pulsed during EXEC of ADD -> next cycle IDLE, loadc/write=0, no rsp_valid; next command completes normally.
REQ-029 cmd_valid held continuously with changing fields -> exactly one command accepted per IDLE visit, fields latched at handshake edge only.
